// File: rtl/req_issuer.sv
// Requester front end for the priority-selector grant network: per-line pending
// counters drive req/en, legal grants retire one request each and pulse done.
// Optional per-line starvation detection is built when REQ_STARVE_EN is defined.
//
// Handshake: a grant is consumed on line i in a cycle when en=1, gnt is one-hot
// or zero, and gnt[i] coincides with req[i]=1; the selector is combinational, so
// gnt is sampled on the same rising edge that retires the request.
module req_issuer #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 2
`ifdef REQ_STARVE_EN
  ,
  parameter int STARVE_LIMIT = 15
`endif
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] new_req,
  input  logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] req,
  output logic               en,
  output logic [NUM_REQ-1:0] done,
  output logic               overflow,
  output logic               proto_err,
`ifdef REQ_STARVE_EN
  output logic [NUM_REQ-1:0] starve,
`endif
  output logic [1:0]         dbg_state
);

  // dbg_state encoding: 0 = IDLE, 1 = ACTIVE, 2 = HALT.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_HALT   = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

`ifdef REQ_STARVE_EN
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(STARVE_LIMIT);
`endif

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q [NUM_REQ];
  logic [CNT_W-1:0]   cnt_d [NUM_REQ];
  logic               en_q, en_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               overflow_q, overflow_d;
  logic               proto_err_q, proto_err_d;

  logic               err;
  logic               accept;
  logic               ovf_hit;
  logic               any_pend_d;
  logic [NUM_REQ-1:0] consume;

`ifdef REQ_STARVE_EN
  logic [AGE_W-1:0]   age_q [NUM_REQ];
  logic [AGE_W-1:0]   age_d [NUM_REQ];
  logic [NUM_REQ-1:0] starve_q, starve_d;
`endif

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req[i] = (cnt_q[i] != '0);
    end
  end

  // Protocol checks are only meaningful while the selector is enabled.
  always_comb begin
    err     = en_q && (((gnt & (gnt - 1'b1)) != '0) || ((gnt & ~req) != '0));
    consume = (en_q && !err) ? gnt : '0;
    accept  = (state_q != ST_HALT) && !err;
  end

  always_comb begin
    ovf_hit    = 1'b0;
    any_pend_d = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (accept) begin
        case ({new_req[i], consume[i]})
          2'b10: begin
            if (cnt_q[i] == CNT_MAX) ovf_hit = 1'b1;
            else                     cnt_d[i] = cnt_q[i] + 1'b1;
          end
          2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
          default: cnt_d[i] = cnt_q[i];
        endcase
      end
      if (cnt_d[i] != '0) any_pend_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (err)                  state_d = ST_HALT;
        else if (new_req != '0)   state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (err)                                    state_d = ST_HALT;
        else if (!any_pend_d && (new_req == '0))    state_d = ST_IDLE;
      end
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    en_d        = !(err || (state_q == ST_HALT));
    done_d      = consume;
    overflow_d  = overflow_q | ovf_hit;
    proto_err_d = proto_err_q | err;
  end

`ifdef REQ_STARVE_EN
  // Age freezes with the counters once halted; it saturates at the limit.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      age_d[i] = age_q[i];
      if (accept) begin
        if (consume[i] || (cnt_q[i] == '0)) age_d[i] = '0;
        else if (age_q[i] != AGE_LIM)       age_d[i] = age_q[i] + 1'b1;
      end
      starve_d[i] = (age_d[i] == AGE_LIM);
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      en_q        <= 1'b1;
      done_q      <= '0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
      proto_err_q <= proto_err_d;
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef REQ_STARVE_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) age_q[i] <= '0;
    end else begin
      starve_q <= starve_d;
      for (int i = 0; i < NUM_REQ; i++) age_q[i] <= age_d[i];
    end
  end

  assign starve = starve_q;
`endif

  assign en        = en_q;
  assign done      = done_q;
  assign overflow  = overflow_q;
  assign proto_err = proto_err_q;
  assign dbg_state = state_q;

endmodule

// File: doc/req_issuer.md
# req_issuer

Requester-side front end for the priority-selector grant network: collects request pulses from NUM_REQ clients, tracks pending requests per line, and drives the level-sensitive `req`/`en` inputs of the selector. It consumes the combinational `gnt` vector, retires one pending request per granted line, reports completions, and flags protocol violations. It sits between client logic and the ps4-class selector tree.

## Interface
- `NUM_REQ`, 4: number of request lines; index NUM_REQ-1 is the highest priority at the selector.
- `CNT_W`, 2: per-line pending-counter width; up to 2^CNT_W-1 outstanding requests per line.
- `STARVE_LIMIT`, 15: cycles a line may stay pending without a grant before `starve` asserts. Used only with `REQ_STARVE_EN`.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `new_req`  in  NUM_REQ  per-client one-cycle request pulses; any mix of bits may be set.
- `gnt`  in  NUM_REQ  grant vector returned by the selector in the same cycle.
- `req`  out  NUM_REQ  to selector; `req[i]` = (pending count i != 0), driven from registered state.
- `en`  out  1  to selector; registered selector enable.
- `done`  out  NUM_REQ  registered one-cycle pulse; `done[i]` marks a grant consumed on line i in the previous cycle.
- `overflow`  out  1  sticky; a request was dropped because its counter was full.
- `proto_err`  out  1  sticky; an illegal grant was observed.
- `starve`  out  NUM_REQ  per-line starvation flags. Present only with `REQ_STARVE_EN`.

## Operation
- FSM states are IDLE, ACTIVE and HALT. Reset enters IDLE.
- IDLE: all counters are zero and `en`=1. Any `new_req` bit moves the FSM to ACTIVE.
- ACTIVE: from ACTIVE the FSM returns to IDLE when every counter reaches 0 and no `new_req` arrives that cycle.
- Any state goes to HALT on a protocol error. HALT is left only by `reset`.
- Per-line counter update on each edge:
  - +1 if `new_req[i]`;
  - -1 if `gnt[i] && req[i] && en`;
  - both events together leave the count unchanged.
- Counter saturation: when count = max, `new_req[i]` without a simultaneous grant is dropped and `overflow` is set. The counter never wraps.
- Protocol error (detected only when `en`=1; sets `proto_err` and the FSM goes to HALT):
  - `gnt` has more than one bit set; or
  - `gnt[i]` is set while `req[i]`=0.
- In HALT:
  - `en`=0 from the next cycle;
  - counters freeze and `new_req` is ignored, with no overflow accounting;
  - `done` stays 0.
- `done` is registered and equals the legal consumed-grant vector of the prior cycle, so it is one-hot or zero.
- Reset values: counters 0, `req`=0, `en`=1, `done`=0, `overflow`=0, `proto_err`=0, `starve`=0, state IDLE.
- Reset asserted mid-operation discards all pending requests. Nothing on `done` reports the discarded requests.

## Timing
- A `new_req[i]` pulse at edge N makes `req[i]`=1 from cycle N+1.
- Grant with `req` held in cycle N (the selector is combinational):
  - the counter decrements at edge N+1;
  - `done[i]` is high during cycle N+1;
  - `req[i]` drops in cycle N+1 only if the count reached 0.
- Back-to-back grants on one line are allowed: one retirement per cycle per line, at most one line per cycle.
- An illegal `gnt` in cycle N gives `proto_err`=1 and `en`=0 from cycle N+1. Any grant in that cycle is not consumed.
- Sticky flags clear only on `reset`.

## Configuration
- `REQ_STARVE_EN` defined:
  - each line has an age counter, sized to hold STARVE_LIMIT, that increments while `req[i]`=1 and no grant occurs;
  - the age counter clears on a grant or when the count is 0;
  - `starve[i]` is registered and asserts when age reaches STARVE_LIMIT. It clears with the age counter.
- `REQ_STARVE_EN` undefined: the `starve` port, the age counters and STARVE_LIMIT logic are absent. All other behaviour is identical.

## Test plan
- Reset, then `new_req`=4'b0101 for one cycle with `gnt`=0 -> `req`=4'b0101 next cycle and state ACTIVE. Then `gnt`=4'b0100 -> `done`=4'b0100 and `req`=4'b0001.
- `new_req[3]` on 4 consecutive cycles, no grants (CNT_W=2) -> count 3, `overflow`=1 after the 4th pulse. Then 3 grant cycles -> three `done[3]` pulses, then `req[3]`=0 and state IDLE.
- `new_req[1]` and `gnt[1]` in the same cycle with count 1 -> count stays 1, `done[1]`=1, `req[1]` remains high.
- `req`=4'b0011 and `gnt`=4'b0011 -> `proto_err`=1, `en`=0 next cycle, counters unchanged, later `new_req` ignored. Then `reset` -> all outputs return to reset values.
- `gnt`=4'b1000 while `req[3]`=0 -> `proto_err`=1 and state HALT.
- With `REQ_STARVE_EN`: `req[0]` held with `gnt` withheld for 15 cycles -> `starve[0]`=1. A grant clears it the following cycle.
